// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection controller slice:
//   - state_t      : controller phase (ALLRED, GREEN, YELLOW, FLASH)
//   - LAMP_*       : bit positions of the per-approach lamp bundle
//   - idx_width()  : width of the approach index, never less than 1
//   - params_ok()  : elaboration-time legality check of timing parameters
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        FLASH  = 2'd3
    } state_t;

    localparam int LAMP_RED    = 0;
    localparam int LAMP_YELLOW = 1;
    localparam int LAMP_GREEN  = 2;
    localparam int LAMP_WALK   = 3;
    localparam int LAMP_N      = 4;

    function automatic int idx_width(input int num_dir);
        return (num_dir <= 2) ? 1 : $clog2(num_dir);
    endfunction

    // Every terminal count (length-1) must fit in the shared phase timer.
    function automatic bit params_ok(input int num_dir, input int cnt_w,
                                     input int green_t, input int yellow_t,
                                     input int allred_t, input int ped_t,
                                     input int flash_h);
        int lim;
        lim = 1 << cnt_w;
        return (num_dir >= 2) && (num_dir <= 4) &&
               (green_t >= 1) && (yellow_t >= 1) && (allred_t >= 1) &&
               (ped_t >= 1) && (flash_h >= 1) &&
               (green_t + ped_t - 1 < lim) && (yellow_t - 1 < lim) &&
               (allred_t - 1 < lim) && (flash_h - 1 < lim);
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_if.sv
// -----------------------------------------------------------------------------
// traffic_intersection_ctrl_if
// Bundle between the timing/config side and the controller.
//   master : config side  - drives enable, flash_mode, ped_req; sees lamps
//   slave  : controller   - receives requests; drives red/yellow/green/walk
//                           and phase_idx
// -----------------------------------------------------------------------------
interface traffic_intersection_ctrl_if
    import traffic_pkg::*;
#(
    parameter int NUM_DIR = 4
);
    localparam int IDX_W = idx_width(NUM_DIR);

    logic               enable;
    logic               flash_mode;
    logic [NUM_DIR-1:0] ped_req;
    logic [NUM_DIR-1:0] red;
    logic [NUM_DIR-1:0] yellow;
    logic [NUM_DIR-1:0] green;
    logic [NUM_DIR-1:0] walk;
    logic [IDX_W-1:0]   phase_idx;

    modport master (
        output enable, flash_mode, ped_req,
        input  red, yellow, green, walk, phase_idx
    );

    modport slave (
        input  enable, flash_mode, ped_req,
        output red, yellow, green, walk, phase_idx
    );
endinterface

// File: rtl/traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// traffic_phase_timer
// Counts 0..last and wraps; done is high on the cycle cnt==last.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart at 0 on the next cycle (forced phase change)
//   hold       : park the count at 0 and suppress done
//   last       : terminal count (phase length - 1)
//   cnt        : current count
//   done       : terminal-count pulse
// -----------------------------------------------------------------------------
module traffic_phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             hold,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);
    assign done = !hold && (cnt == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || hold || done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/traffic_intersection_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_intersection_ctrl
// Round-robin controller for NUM_DIR approaches with all-red clearance,
// latched pedestrian requests that extend green with a walk lamp, a
// flashing-yellow mode and an enable that parks the junction in all-red.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of traffic_intersection_ctrl_if
//                in : enable, flash_mode, ped_req[NUM_DIR]
//                out: red/yellow/green/walk[NUM_DIR], phase_idx
// Lamps are a Moore decode of the registered state.
// -----------------------------------------------------------------------------
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR     = 4,
    parameter int CNT_W       = 5,
    parameter int GREEN_TIME  = 8,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int PED_TIME    = 4,
    parameter int FLASH_HALF  = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    traffic_intersection_ctrl_if.slave   bus
);
    localparam int IDX_W = idx_width(NUM_DIR);
    localparam bit PARAMS_OK = params_ok(NUM_DIR, CNT_W, GREEN_TIME, YELLOW_TIME,
                                         ALLRED_TIME, PED_TIME, FLASH_HALF);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("traffic_intersection_ctrl: illegal timing parameters");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   phase_q, phase_d;
    logic               ext_q, ext_d;        // current green carries a walk
    logic               toggle_q, toggle_d;  // flash lamp phase
    logic [NUM_DIR-1:0] latch_q, clr_mask;
    logic               tmr_clear, tmr_hold, tmr_done, walk_on;
    logic [CNT_W-1:0]   tmr_last, tmr_cnt;
    logic [LAMP_N-1:0]  lamp [NUM_DIR];
    logic [NUM_DIR-1:0] red_v, yellow_v, green_v, walk_v;

    // Parked in all-red: only when disabled and no flash request pending,
    // so a flash request still completes the clearance and enters FLASH.
    assign tmr_hold  = (state_q == ALLRED) && !bus.enable && !bus.flash_mode;
    assign tmr_clear = ((state_q == GREEN) && (bus.flash_mode || !bus.enable)) ||
                       ((state_q == FLASH) && !bus.flash_mode);

    always_comb begin
        tmr_last = CNT_W'(ALLRED_TIME - 1);
        case (state_q)
            GREEN:   tmr_last = ext_q ? CNT_W'(GREEN_TIME + PED_TIME - 1)
                                      : CNT_W'(GREEN_TIME - 1);
            YELLOW:  tmr_last = CNT_W'(YELLOW_TIME - 1);
            FLASH:   tmr_last = CNT_W'(FLASH_HALF - 1);
            default: tmr_last = CNT_W'(ALLRED_TIME - 1);
        endcase
    end

    traffic_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tmr_clear),
        .hold  (tmr_hold),
        .last  (tmr_last),
        .cnt   (tmr_cnt),
        .done  (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        ext_d    = ext_q;
        toggle_d = toggle_q;
        clr_mask = '0;
        case (state_q)
            ALLRED: begin
                if (tmr_done) begin
                    if (bus.flash_mode) begin
                        state_d = FLASH;
                    end else begin
                        state_d           = GREEN;
                        ext_d             = latch_q[phase_q];
                        clr_mask[phase_q] = 1'b1;
                    end
                end
            end
            GREEN: begin
                if (tmr_clear || tmr_done) begin
                    state_d = YELLOW;
                end
            end
            YELLOW: begin
                if (tmr_done) begin
                    state_d = ALLRED;
                    phase_d = (phase_q == IDX_W'(NUM_DIR - 1)) ? '0 : phase_q + 1'b1;
                end
            end
            FLASH: begin
                if (!bus.flash_mode) begin
                    state_d  = ALLRED;
                    phase_d  = '0;
                    toggle_d = 1'b0;
                end else if (tmr_done) begin
                    toggle_d = ~toggle_q;
                end
            end
            default: state_d = ALLRED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ALLRED;
            phase_q  <= '0;
            ext_q    <= 1'b0;
            toggle_q <= 1'b0;
            latch_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            ext_q    <= ext_d;
            toggle_q <= toggle_d;
            // Clear only the bit being served; a request arriving on the same
            // cycle re-arms it for that approach's next turn.
            latch_q  <= (latch_q & ~clr_mask) | bus.ped_req;
        end
    end

    // Walk covers the base green only; the PED_TIME tail is plain green.
    assign walk_on = ext_q && (tmr_cnt < CNT_W'(GREEN_TIME));

    always_comb begin
        for (int i = 0; i < NUM_DIR; i++) begin
            lamp[i] = '0;
            case (state_q)
                GREEN: begin
                    if (phase_q == IDX_W'(i)) begin
                        lamp[i][LAMP_GREEN] = 1'b1;
                        lamp[i][LAMP_WALK]  = walk_on;
                    end else begin
                        lamp[i][LAMP_RED] = 1'b1;
                    end
                end
                YELLOW: begin
                    if (phase_q == IDX_W'(i)) lamp[i][LAMP_YELLOW] = 1'b1;
                    else                      lamp[i][LAMP_RED]    = 1'b1;
                end
                FLASH:   lamp[i][LAMP_YELLOW] = toggle_q;
                default: lamp[i][LAMP_RED]    = 1'b1;
            endcase
        end
    end

    always_comb begin
        red_v    = '0;
        yellow_v = '0;
        green_v  = '0;
        walk_v   = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            red_v[i]    = lamp[i][LAMP_RED];
            yellow_v[i] = lamp[i][LAMP_YELLOW];
            green_v[i]  = lamp[i][LAMP_GREEN];
            walk_v[i]   = lamp[i][LAMP_WALK];
        end
    end

    assign bus.red       = red_v;
    assign bus.yellow    = yellow_v;
    assign bus.green     = green_v;
    assign bus.walk      = walk_v;
    assign bus.phase_idx = phase_q;
endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_intersection_ctrl
// Directed bench for traffic_intersection_ctrl at default parameters.
// Expected lamp sequences are written as hand-derived segments
// (all-red / green / green+walk / yellow / flash dark / flash lit).
// -----------------------------------------------------------------------------
module tb_traffic_intersection_ctrl;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] y;
        logic [3:0] g;
        logic [3:0] w;
        logic [1:0] p;
    } exp_t;

    localparam int K_RED = 0, K_GRN = 1, K_GRNW = 2, K_YEL = 3, K_DARK = 4, K_LIT = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    exp_t got;

    traffic_intersection_ctrl_if #(.NUM_DIR(4)) bus ();

    traffic_intersection_ctrl #(
        .NUM_DIR(4), .CNT_W(5), .GREEN_TIME(8), .YELLOW_TIME(3),
        .ALLRED_TIME(2), .PED_TIME(4), .FLASH_HALF(5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add_seg(input int n, input int kind, input int a);
        exp_t       e;
        logic [3:0] oh;
        oh  = 4'b0001 << a;
        e   = '0;
        e.p = 2'(a);
        case (kind)
            K_RED:   e.r = 4'hf;
            K_GRN:   begin e.r = ~oh; e.g = oh; end
            K_GRNW:  begin e.r = ~oh; e.g = oh; e.w = oh; end
            K_YEL:   begin e.r = ~oh; e.y = oh; end
            K_LIT:   e.y = 4'hf;
            default: e.y = 4'h0;
        endcase
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endfunction

    function automatic void add_turn(input int a, input bit ext);
        add_seg(2, K_RED, a);
        if (ext) begin
            add_seg(8, K_GRNW, a);
            add_seg(4, K_GRN, a);
        end else begin
            add_seg(8, K_GRN, a);
        end
        add_seg(3, K_YEL, a);
    endfunction

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.enable     = 1'b1;
        bus.flash_mode = 1'b0;
        bus.ped_req    = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b1;
        bus.enable     = 1'b1;
        bus.flash_mode = 1'b0;
        bus.ped_req    = 4'b0000;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.red !== 4'b1111) begin
            n_fail++; $display("FAIL reset_red: got %b expected 1111", bus.red);
        end
        n_checks++;
        if (bus.yellow !== 4'b0000) begin
            n_fail++; $display("FAIL reset_yellow: got %b expected 0000", bus.yellow);
        end
        n_checks++;
        if (bus.green !== 4'b0000) begin
            n_fail++; $display("FAIL reset_green: got %b expected 0000", bus.green);
        end
        n_checks++;
        if (bus.walk !== 4'b0000) begin
            n_fail++; $display("FAIL reset_walk: got %b expected 0000", bus.walk);
        end
        n_checks++;
        if (bus.phase_idx !== 2'd0) begin
            n_fail++; $display("FAIL reset_phase: got %0d expected 0", bus.phase_idx);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        exp_q.delete();
        for (int a = 0; a < 4; a++) add_turn(a, 1'b0);
        add_seg(2, K_RED, 0);
        add_seg(1, K_GRN, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            #1;
            got = {bus.red, bus.yellow, bus.green, bus.walk, bus.phase_idx};
            n_checks++;
            if (got !== exp_q[k]) begin
                n_fail++;
                $display("FAIL rotation cyc %0d: got r%b y%b g%b w%b p%0d expected r%b y%b g%b w%b p%0d",
                         k, got.r, got.y, got.g, got.w, got.p,
                         exp_q[k].r, exp_q[k].y, exp_q[k].g, exp_q[k].w, exp_q[k].p);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ped_extend();
        do_reset();
        exp_q.delete();
        add_turn(0, 1'b0); add_turn(1, 1'b0); add_turn(2, 1'b1); add_turn(3, 1'b0);
        add_turn(0, 1'b0); add_turn(1, 1'b0); add_turn(2, 1'b0);
        add_seg(2, K_RED, 3);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 5) bus.ped_req = 4'b0100;
            if (k == 6) bus.ped_req = 4'b0000;
            #1;
            got = {bus.red, bus.yellow, bus.green, bus.walk, bus.phase_idx};
            n_checks++;
            if (got !== exp_q[k]) begin
                n_fail++;
                $display("FAIL ped_extend cyc %0d: got r%b y%b g%b w%b p%0d expected r%b y%b g%b w%b p%0d",
                         k, got.r, got.y, got.g, got.w, got.p,
                         exp_q[k].r, exp_q[k].y, exp_q[k].g, exp_q[k].w, exp_q[k].p);
            end
            @(negedge clk);
        end
    endtask

    // Approach 1: request on its first green cycle. Approach 3: request on the
    // last all-red cycle before its green, while its latch is being served.
    task automatic test_ped_entry();
        do_reset();
        exp_q.delete();
        add_turn(0, 1'b0); add_turn(1, 1'b0); add_turn(2, 1'b0); add_turn(3, 1'b0);
        add_turn(0, 1'b0); add_turn(1, 1'b1); add_turn(2, 1'b0); add_turn(3, 1'b1);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 15) bus.ped_req = 4'b0010;
            if (k == 40) bus.ped_req = 4'b1000;
            if (k == 16 || k == 41) bus.ped_req = 4'b0000;
            #1;
            got = {bus.red, bus.yellow, bus.green, bus.walk, bus.phase_idx};
            n_checks++;
            if (got !== exp_q[k]) begin
                n_fail++;
                $display("FAIL ped_entry cyc %0d: got r%b y%b g%b w%b p%0d expected r%b y%b g%b w%b p%0d",
                         k, got.r, got.y, got.g, got.w, got.p,
                         exp_q[k].r, exp_q[k].y, exp_q[k].g, exp_q[k].w, exp_q[k].p);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flash();
        do_reset();
        exp_q.delete();
        add_seg(2, K_RED, 0);
        add_seg(4, K_GRN, 0);
        add_seg(3, K_YEL, 0);
        add_seg(2, K_RED, 1);
        add_seg(5, K_DARK, 1);
        add_seg(5, K_LIT, 1);
        add_seg(5, K_DARK, 1);
        add_seg(5, K_LIT, 1);
        add_seg(1, K_DARK, 1);
        add_seg(2, K_RED, 0);
        add_seg(8, K_GRN, 0);
        add_seg(3, K_YEL, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 5)  bus.flash_mode = 1'b1;
            if (k == 31) bus.flash_mode = 1'b0;
            #1;
            got = {bus.red, bus.yellow, bus.green, bus.walk, bus.phase_idx};
            n_checks++;
            if (got !== exp_q[k]) begin
                n_fail++;
                $display("FAIL flash cyc %0d: got r%b y%b g%b w%b p%0d expected r%b y%b g%b w%b p%0d",
                         k, got.r, got.y, got.g, got.w, got.p,
                         exp_q[k].r, exp_q[k].y, exp_q[k].g, exp_q[k].w, exp_q[k].p);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_enable();
        do_reset();
        exp_q.delete();
        add_seg(2, K_RED, 0);
        add_seg(4, K_GRN, 0);
        add_seg(3, K_YEL, 0);
        add_seg(13, K_RED, 1);
        add_seg(8, K_GRN, 1);
        add_seg(3, K_YEL, 1);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 5)  bus.enable = 1'b0;
            if (k == 20) bus.enable = 1'b1;
            #1;
            got = {bus.red, bus.yellow, bus.green, bus.walk, bus.phase_idx};
            n_checks++;
            if (got !== exp_q[k]) begin
                n_fail++;
                $display("FAIL enable cyc %0d: got r%b y%b g%b w%b p%0d expected r%b y%b g%b w%b p%0d",
                         k, got.r, got.y, got.g, got.w, got.p,
                         exp_q[k].r, exp_q[k].y, exp_q[k].g, exp_q[k].w, exp_q[k].p);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_phase();
        do_reset();
        exp_q.delete();
        add_turn(0, 1'b0);
        add_seg(2, K_RED, 1);
        add_seg(8, K_GRN, 1);
        add_seg(1, K_YEL, 1);
        add_seg(1, K_RED, 0);
        add_turn(0, 1'b0);
        add_seg(2, K_RED, 1);
        add_seg(1, K_GRN, 1);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 24) rst_n = 1'b0;
            if (k == 25) rst_n = 1'b1;
            #1;
            got = {bus.red, bus.yellow, bus.green, bus.walk, bus.phase_idx};
            n_checks++;
            if (got !== exp_q[k]) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got r%b y%b g%b w%b p%0d expected r%b y%b g%b w%b p%0d",
                         k, got.r, got.y, got.g, got.w, got.p,
                         exp_q[k].r, exp_q[k].y, exp_q[k].g, exp_q[k].w, exp_q[k].p);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_rotation();
        test_ped_extend();
        test_ped_entry();
        test_flash();
        test_enable();
        test_reset_mid_phase();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_intersection_ctrl.md
# traffic_intersection_ctrl

Parametrised multi-approach intersection controller, successor to the single-signal red/green/yellow sequencer. Serves NUM_DIR approaches round-robin with an all-red clearance between phases, latched pedestrian requests that extend green with a walk indication, and a flashing-yellow fault/night mode. Sits between the timing/config registers and the lamp-driver outputs.

## Interface
- NUM_DIR, 4: number of approaches, 2..4.
- CNT_W, 5: phase-timer width; must hold GREEN_TIME+PED_TIME-1.
- GREEN_TIME, 8: base green cycles, >=1.
- YELLOW_TIME, 3: yellow cycles, >=1.
- ALLRED_TIME, 2: all-red clearance cycles, >=1.
- PED_TIME, 4: extra green cycles when a walk is served, >=1.
- FLASH_HALF, 5: flash half-period in cycles, >=1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = run the cycle; 0 = park in all-red.
- flash_mode  in  1  level request for flashing-yellow mode.
- ped_req  in  NUM_DIR  one-cycle or level pedestrian request per approach.
- red  out  NUM_DIR  red lamp per approach.
- yellow  out  NUM_DIR  yellow lamp per approach.
- green  out  NUM_DIR  green lamp per approach.
- walk  out  NUM_DIR  walk lamp per approach.
- phase_idx  out  max(1,$clog2(NUM_DIR))  approach currently owning green/yellow.

## Operation
- States: ALLRED, GREEN, YELLOW, FLASH. Reset: ALLRED, phase_idx=0, timer=0, ped latches clear, flash toggle 0.
- Outputs are Moore decode of registered state. ALLRED: red all 1. GREEN: green[phase_idx]=1, others red. YELLOW: yellow[phase_idx]=1, others red. FLASH: yellow = all toggle bit, red/green/walk 0. Exactly one of red/yellow/green per approach outside FLASH.
- Reset values of all outputs: red all 1, yellow/green/walk all 0, phase_idx 0.
- Timer counts 0..T-1 in each state; transition when timer==T-1, timer returns to 0. A state of length T is active exactly T cycles.
- ALLRED(ALLRED_TIME) -> GREEN. phase_idx advances (mod NUM_DIR) on YELLOW->ALLRED, not on entry to GREEN; first green after reset is approach 0.
- On GREEN entry: if ped latch[phase_idx] set, green length = GREEN_TIME+PED_TIME, walk[phase_idx]=1 for the first GREEN_TIME cycles of that green, latch cleared on the entry cycle; else length GREEN_TIME, walk 0.
- ped_req[i] sets latch[i] on any cycle; a request on the GREEN entry cycle for that approach is kept for its next turn (clear has priority only for the pre-existing bit, set wins for the new one).
- GREEN -> YELLOW(YELLOW_TIME) -> ALLRED.
- flash_mode=1 sampled in GREEN: go to YELLOW next cycle, timer 0 (no green cut shorter than 1 cycle). In YELLOW: finish normally. In ALLRED: complete clearance, then FLASH instead of GREEN. In FLASH, toggle bit inverts every FLASH_HALF cycles.
- flash_mode=0 in FLASH: -> ALLRED with full ALLRED_TIME, phase_idx=0, toggle cleared.
- enable=0: same as flash request path but destination is ALLRED held (timer held 0) until enable=1; flash_mode has priority over enable. Ped latches keep collecting.
- rst_n assertion mid-phase: all outputs return to reset values immediately (asynchronous).

## Timing
- Latency ped_req -> latch: 1 cycle; served at that approach's next GREEN entry.
- flash_mode rise in GREEN -> yellow visible next cycle -> FLASH after YELLOW_TIME+ALLRED_TIME more cycles.
- Full cycle without requests: NUM_DIR*(GREEN_TIME+YELLOW_TIME+ALLRED_TIME) cycles.

## Structure
- Shared package traffic_pkg: state enum (ALLRED, GREEN, YELLOW, FLASH), lamp-index constants, parameter-legality helper function.
- One sub-module: traffic_phase_timer (load length, count, done pulse at T-1, hold input); reused for flash half-period.

## Test plan
- Defaults, no requests, release reset -> red=4'b1111 for 2 cycles, green=4'b0001 8 cycles, yellow=4'b0001 3 cycles, 2 all-red, then green=4'b0010; full rotation 52 cycles.
- ped_req[2] pulse at cycle 5 -> approach 2 green for 12 cycles, walk[2]=1 first 8 of them; approach 2 next turn green 8 cycles only.
- ped_req[1] on the cycle approach 1 enters green -> that green unextended; next approach-1 green 12 cycles with walk.
- flash_mode=1 at green cycle 3 -> yellow next cycle for 3, all-red 2, then yellow=4'b1111/4'b0000 alternating every 5 cycles; drop flash_mode -> 2 all-red cycles, green=4'b0001.
- enable=0 mid-green -> yellow 3, all-red held indefinitely; enable=1 -> green after 2 more all-red cycles on next approach.
- rst_n low for 1 cycle mid-yellow -> outputs immediately red=4'b1111, phase_idx=0; sequence restarts as scenario 1.
